call_return_stack: RTL and testbench

//   Hardware return-address stack that produces the FROM_STACK value consumed by the PC mux.
//   The control unit pushes the return address when a CALL executes.
//   It pops on RET/RETIE, and the top entry is then loaded into the program counter.

---
 rtl/call_return_stack.sv | 97 +++++++++
 tb/tb_call_return_stack.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/call_return_stack.sv
// Hardware return-address stack: CALL pushes the return address, RET/RETIE pops,
// and the current top is presented combinationally to the PC mux.
module call_return_stack #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       PUSH,
    input  logic                       POP,
    input  logic [DATA_W-1:0]          PUSH_DATA,
    input  logic                       CLR_ERR,
    output logic [DATA_W-1:0]          FROM_STACK,
    output logic [$clog2(DEPTH):0]     SP,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned SP_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     top_idx;
    logic              empty_c, full_c;

    assign empty_c = (sp_q == '0);
    assign full_c  = (sp_q == SP_W'(DEPTH));
    assign top_idx = AW'(sp_q - SP_W'(1));

    // Next stack pointer, write port and error flag updates
    always_comb begin
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_addr = AW'(sp_q);
        ovf_d   = ovf_q & ~CLR_ERR;
        unf_d   = unf_q & ~CLR_ERR;
        case ({PUSH, POP})
            2'b10: begin
                if (full_c) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + SP_W'(1);
                end
            end
            2'b01: begin
                if (empty_c) begin
                    unf_d = 1'b1;
                end else begin
                    sp_d = sp_q - SP_W'(1);
                end
            end
            2'b11: begin
                // Replace the top; on an empty stack this degenerates to a plain push.
                wr_en = 1'b1;
                if (empty_c) begin
                    wr_addr = '0;
                    sp_d    = SP_W'(1);
                end else begin
                    wr_addr = top_idx;
                end
            end
            default: ;
        endcase
    end

    // Pointer and flags reset; storage is never cleared and is not written during reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (wr_en) begin
                mem[wr_addr] <= PUSH_DATA;
            end
        end
    end

    assign FROM_STACK = empty_c ? '0 : mem[top_idx];
    assign SP         = sp_q;
    assign EMPTY      = empty_c;
    assign FULL       = full_c;
    assign OVERFLOW   = ovf_q;
    assign UNDERFLOW  = unf_q;

endmodule

// File: tb/tb_call_return_stack.sv
// Self-checking bench for call_return_stack: behavioural reference model feeds a
// scoreboard queue of expected outputs, plus fixed-value checks on the key scenarios.
module tb_call_return_stack;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned SP_W   = $clog2(DEPTH) + 1;

    typedef struct {
        logic [SP_W-1:0]   sp;
        logic [DATA_W-1:0] top;
        logic              empty;
        logic              full;
        logic              ovf;
        logic              unf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              push, pop, clr_err;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] from_stack;
    logic [SP_W-1:0]   sp;
    logic              empty, full, overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

    exp_t              sb[$];
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_sp;
    logic              m_ovf, m_unf;

    call_return_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .PUSH(push), .POP(pop), .PUSH_DATA(push_data),
        .CLR_ERR(clr_err), .FROM_STACK(from_stack), .SP(sp), .EMPTY(empty),
        .FULL(full), .OVERFLOW(overflow), .UNDERFLOW(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.sp    = SP_W'(m_sp);
        e.top   = (m_sp == 0) ? '0 : m_mem[m_sp-1];
        e.empty = (m_sp == 0);
        e.full  = (m_sp == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic model_step(input logic p_push, input logic p_pop,
                              input logic [DATA_W-1:0] d, input logic p_clr);
        logic ovs, uns;
        ovs = 1'b0;
        uns = 1'b0;
        if (p_push && !p_pop) begin
            if (m_sp == DEPTH) ovs = 1'b1;
            else begin m_mem[m_sp] = d; m_sp++; end
        end else if (!p_push && p_pop) begin
            if (m_sp == 0) uns = 1'b1;
            else m_sp--;
        end else if (p_push && p_pop) begin
            if (m_sp == 0) begin m_mem[0] = d; m_sp = 1; end
            else m_mem[m_sp-1] = d;
        end
        m_ovf = ovs | (m_ovf & ~p_clr);
        m_unf = uns | (m_unf & ~p_clr);
    endtask

    task automatic compare_sb();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underrun", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sp",         32'(sp),         32'(e.sp));
            check("from_stack", 32'(from_stack), 32'(e.top));
            check("empty",      32'(empty),      32'(e.empty));
            check("full",       32'(full),       32'(e.full));
            check("overflow",   32'(overflow),   32'(e.ovf));
            check("underflow",  32'(underflow),  32'(e.unf));
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, compare just after the rising edge.
    task automatic step(input logic p_push, input logic p_pop,
                        input logic [DATA_W-1:0] d, input logic p_clr);
        @(negedge clk);
        push = p_push; pop = p_pop; push_data = d; clr_err = p_clr;
        model_step(p_push, p_pop, d, p_clr);
        sb.push_back(model_expect());
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        compare_sb();
    endtask

    task automatic model_reset();
        m_sp  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;
        model_reset();
        #2;
        // Reset state
        sb.push_back(model_expect());
        compare_sb();
        check("rst_from_stack", 32'(from_stack), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two pushes, two pops
        step(1'b1, 1'b0, 10'h0A5, 1'b0);
        step(1'b1, 1'b0, 10'h1FF, 1'b0);
        check("t2_top", 32'(from_stack), 32'h1FF);
        check("t2_sp",  32'(sp), 32'd2);
        step(1'b0, 1'b1, '0, 1'b0);
        check("t2_pop1", 32'(from_stack), 32'h0A5);
        step(1'b0, 1'b1, '0, 1'b0);
        check("t2_pop2_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain
        for (int i = 1; i <= 32; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_top",  32'(from_stack), 32'h020);
        step(1'b1, 1'b0, 10'h3AA, 1'b0);
        check("t3_ovf",     32'(overflow), 32'd1);
        check("t3_ovf_top", 32'(from_stack), 32'h020);
        for (int i = 32; i >= 1; i--) begin
            check("t3_drain", 32'(from_stack), 32'(i));
            step(1'b0, 1'b1, '0, 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Underflow, clear racing a new error, then clean clear
        step(1'b0, 1'b1, '0, 1'b0);
        check("t4_unf", 32'(underflow), 32'd1);
        step(1'b0, 1'b1, '0, 1'b1);
        check("t4_set_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("t4_unf_clr", 32'(underflow), 32'd0);

        // Simultaneous push+pop
        step(1'b1, 1'b0, 10'h011, 1'b0);
        step(1'b1, 1'b1, 10'h222, 1'b0);
        check("t5_replace", 32'(from_stack), 32'h222);
        check("t5_sp1",     32'(sp), 32'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, 10'h055, 1'b0);
        check("t5_empty_pp", 32'(from_stack), 32'h055);
        check("t5_no_unf",   32'(underflow), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DATA_W'($urandom), 1'($urandom_range(0, 7) == 0));

        // Async reset in the middle of a push
        while (m_sp > 0) step(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_W'(10'h100 + i), 1'b0);
        check("t6_sp3", 32'(sp), 32'd3);
        @(negedge clk);
        push = 1'b1; push_data = 10'h3C3;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_sp",    32'(sp), 32'd0);
        check("t6_async_empty", 32'(empty), 32'd1);
        push = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(model_expect());
        compare_sb();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 10'h077, 1'b0);
        check("t6_push_top", 32'(from_stack), 32'h077);
        check("t6_push_sp",  32'(sp), 32'd1);

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
